icache_l0: RTL
==============

Name: icache_l0

Overview:
- Small direct-mapped, one-word-per-line instruction cache between the fetch stage's AXI-lite AR request and the memory-side AXI-lite read port.
- Accepts one fetch address at a time and answers hits from local storage.
- On a miss, issues a single-beat read to memory and fills the line.
- Returns the instruction word and response to the fetch stage on an R-style valid/ready channel.

Parameters:
- NSETS, 16, number of lines; power of two, at least 2. IDX_W = log2(NSETS). TAG_W = 30 - IDX_W.
- CACHE_BASE, 32'h30000000, base of the cacheable region.
- CACHE_MASK, 32'hF0000000, region match mask. An address is cacheable when (addr & CACHE_MASK) == CACHE_BASE.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- flush_i  in  1  invalidate all lines (fence.i / ifetch-stale event).
- araddr_i  in  32  fetch address from the fetch stage.
- arvalid_i  in  1  fetch request valid.
- arready_o  out  1  fetch request accepted.
- rdata_o  out  32  instruction word.
- rresp_o  out  2  AXI response code (00 OKAY, 10 SLVERR).
- rvalid_o  out  1  response valid.
- rready_i  in  1  fetch stage consumes the response.
- m_araddr_o  out  32  memory read address.
- m_arvalid_o  out  1  memory read request.
- m_arready_i  in  1  memory accepts the request.
- m_rdata_i  in  32  memory read data.
- m_rresp_i  in  2  memory response code.
- m_rvalid_i  in  1  memory data valid.
- m_rready_o  out  1  cache ready for memory data.

Behaviour:
- Reset (rst_n_i low, takes effect asynchronously):
  - state = IDLE; all valid bits cleared.
  - Outputs: arready_o=1, rvalid_o=0, m_arvalid_o=0, m_rready_o=0, rdata_o=0, rresp_o=0, m_araddr_o=0.
  - Reset mid-miss abandons the transaction; the memory side must also be reset.
- Address split: idx = addr[IDX_W+1:2], tag = addr[31:IDX_W+2]. Data and tag arrays are flops, NSETS entries.
- FSM states and transitions:
  - IDLE: arready_o=1. On arvalid_i && arready_o, latch the address into req_addr and go to LOOKUP.
  - LOOKUP: one cycle, arready_o=0.
    - If req_addr[1:0] != 0: rresp=10, rdata=0, go to RESP. No memory access.
    - Hit (valid[idx] && tag match && cacheable): load rdata from the array, rresp=00, go to RESP.
    - Otherwise go to MISS_AR.
  - MISS_AR: m_arvalid_o=1 and m_araddr_o=req_addr, both held stable until m_arready_i; then go to MISS_R.
  - MISS_R: m_rready_o=1. On m_rvalid_i:
    - Latch m_rdata_i and m_rresp_i into the output registers and go to RESP.
    - Write the line (data, tag, valid=1) only if m_rresp_i==00, the address is cacheable, and no flush was seen during this miss.
  - RESP: rvalid_o=1; rdata_o and rresp_o are held stable until rready_i. On handshake go to IDLE.
- Latency from AR handshake to rvalid_o: hit = 2 cycles; miss = 2 + memory AR wait + memory R wait.
- Non-cacheable addresses always take the miss path and never allocate.
- flush_i:
  - Clears every valid bit the same cycle, in any state.
  - If asserted in MISS_AR or MISS_R, set flush_seen; that miss still returns data to the fetch stage but does not allocate. flush_seen clears on entry to IDLE.
  - flush_i in the same cycle as a fill write: the flush wins and the line stays invalid.
  - flush_i during LOOKUP: forces a miss for that request.
- Error responses (rresp != 00) are forwarded unchanged and never cached.

Decomposition:
- Shared package/header (alongside the existing riscv_param/csr headers):
  - AXI response codes RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - The FSM state encoding (IDLE, LOOKUP, MISS_AR, MISS_R, RESP).
- One natural sub-module: icache_l0_array, holding the tag/valid/data storage.
  - Combinational read by idx.
  - Synchronous single write port.
  - Asynchronous clear of the valid bits on reset, synchronous clear on flush.

Test Plan:
- Cold miss then hit: fetch 0x30000000, memory returns 0x00000413 after 3 cycles → rvalid_o with rdata_o=0x00000413, rresp_o=00. Refetch 0x30000000 → rvalid_o 2 cycles after AR handshake, m_arvalid_o stays 0.
- Conflict eviction (NSETS=16): fetch 0x30000000 then 0x30000040 (same idx 0). The second fetch misses and refills. Refetching 0x30000000 misses again.
- Flush mid-miss: fetch 0x30000008, assert flush_i in MISS_R, memory returns 0x12345678 → fetch stage receives 0x12345678, and an immediate refetch of 0x30000008 misses.
- Backpressure and errors:
  - Hold rready_i=0 for 5 cycles in RESP → rvalid_o, rdata_o and rresp_o stay stable, arready_o=0.
  - Memory returns m_rresp_i=10 → rresp_o=10 forwarded, and a refetch misses.
- Uncached region and misaligned fetch:
  - Fetch 0x80000000 twice → two memory reads, no allocation.
  - Fetch 0x30000002 → rresp_o=10 after 2 cycles, no m_arvalid_o.
- Async reset mid-MISS_AR → outputs return to reset values immediately, and the next fetch of a previously cached address misses.

Source files
------------

// File: rtl/icache_l0_pkg.sv
// Shared types for the L0 instruction cache: AXI response codes, FSM states and
// the cacheable-region predicate.
package icache_l0_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StMissAr,
    StMissR,
    StResp
  } state_e;

  function automatic logic is_cacheable(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/icache_l0_if.sv
// AXI-lite read channel pair (AR + R) used on both the fetch side and the
// memory side of the cache.
interface icache_l0_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/icache_l0_array.sv
// Direct-mapped tag/valid/data storage: combinational read, one synchronous write
// port. Flush clears every valid bit and takes priority over a same-cycle fill.
module icache_l0_array #(
  parameter int unsigned NSETS = 16,
  parameter int unsigned IDX_W = 4,
  parameter int unsigned TAG_W = 26
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_valid_o,
  output logic [TAG_W-1:0] rd_tag_o,
  output logic [31:0]      rd_data_o,
  input  logic             we_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic [31:0]      wr_data_i
);

  logic [NSETS-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [NSETS];
  logic [31:0]      data_q [NSETS];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag and data need no reset: they are only observed through valid_q.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache_l0.sv
// L0 instruction cache: one outstanding fetch, hits answered from local flops,
// misses forwarded as a single-beat AXI-lite read and filled on OKAY.
module icache_l0
  import icache_l0_pkg::*;
#(
  parameter int unsigned NSETS      = 16,
  parameter logic [31:0] CACHE_BASE = 32'h3000_0000,
  parameter logic [31:0] CACHE_MASK = 32'hF000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        flush_i,
  icache_l0_if.slave  fetch_if,
  icache_l0_if.master mem_if
);

  localparam int unsigned IDX_W = $clog2(NSETS);
  localparam int unsigned TAG_W = 30 - IDX_W;

  state_e      state_q, state_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        flush_seen_q, flush_seen_d;

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             req_cacheable;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_data;
  logic             hit;
  logic             fill_we;

  assign req_idx       = req_addr_q[IDX_W+1:2];
  assign req_tag       = req_addr_q[31:IDX_W+2];
  assign req_cacheable = is_cacheable(req_addr_q, CACHE_BASE, CACHE_MASK);
  // A flush in the lookup cycle must not let a soon-to-be-invalid line hit.
  assign hit           = rd_valid && (rd_tag == req_tag) && req_cacheable && !flush_i;

  icache_l0_array #(
    .NSETS (NSETS),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .flush_i    (flush_i),
    .rd_idx_i   (req_idx),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .we_i       (fill_we),
    .wr_idx_i   (req_idx),
    .wr_tag_i   (req_tag),
    .wr_data_i  (mem_if.rdata)
  );

  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    rdata_d      = rdata_q;
    rresp_d      = rresp_q;
    flush_seen_d = flush_seen_q;
    fill_we      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (fetch_if.arvalid) begin
          req_addr_d = fetch_if.araddr;
          state_d    = StLookup;
        end
      end
      StLookup: begin
        if (req_addr_q[1:0] != 2'b00) begin
          rdata_d = '0;
          rresp_d = RESP_SLVERR;
          state_d = StResp;
        end else if (hit) begin
          rdata_d = rd_data;
          rresp_d = RESP_OKAY;
          state_d = StResp;
        end else begin
          state_d = StMissAr;
        end
      end
      StMissAr: begin
        if (mem_if.arready) state_d = StMissR;
      end
      StMissR: begin
        if (mem_if.rvalid) begin
          rdata_d = mem_if.rdata;
          rresp_d = mem_if.rresp;
          state_d = StResp;
          fill_we = (mem_if.rresp == RESP_OKAY) && req_cacheable && !flush_seen_q;
        end
      end
      StResp: begin
        if (fetch_if.rready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (flush_i && (state_q == StMissAr || state_q == StMissR)) flush_seen_d = 1'b1;
    if (state_d == StIdle) flush_seen_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= StIdle;
      req_addr_q   <= '0;
      rdata_q      <= '0;
      rresp_q      <= RESP_OKAY;
      flush_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
      flush_seen_q <= flush_seen_d;
    end
  end

  assign fetch_if.arready = (state_q == StIdle);
  assign fetch_if.rvalid  = (state_q == StResp);
  assign fetch_if.rdata   = rdata_q;
  assign fetch_if.rresp   = rresp_q;

  assign mem_if.arvalid = (state_q == StMissAr);
  assign mem_if.araddr  = (state_q == StMissAr) ? req_addr_q : '0;
  assign mem_if.rready  = (state_q == StMissR);

endmodule
